lcd_rx_timing: RTL
==================

# lcd_rx_timing

Receive-side companion to the RGB LCD timing generator: it samples a DE-mode RGB888 video stream (DE framing only; HS/VS not used for timing), recovers per-pixel X/Y coordinates, and measures the active resolution of each frame. Each frame is checked against the previous one, and the block reports a lock flag and a decoded panel ID in the same 16-bit code space as `lcd_id`. It sits at a video input port, or on a loop-back from an LCD output for self-test, and feeds frame buffers or line processors.

## Interface
- `VBLANK_MIN`, 4096: DE-low run length in cycles that marks a frame boundary; must be greater than the longest horizontal blank.
- `lcd_pclk`  in  1  pixel clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `lcd_de`  in  1  data enable, synchronous to `lcd_pclk`.
- `lcd_rgb`  in  24  RGB888 pixel data, valid while `lcd_de`=1.
- `pixel_valid`  out  1  registered `lcd_de`, gated by state (see Operation).
- `pixel_data`  out  24  registered `lcd_rgb`.
- `pixel_xpos`  out  11  column of the current pixel, starting at 0.
- `pixel_ypos`  out  11  row of the current pixel, starting at 0.
- `frame_start`  out  1  one-cycle pulse, coincident with pixel (0,0).
- `line_done`  out  1  one-cycle pulse, the cycle after the last pixel of each line.
- `frame_done`  out  1  one-cycle pulse when the blank run reaches `VBLANK_MIN`.
- `h_disp`  out  11  measured active width, updated at `frame_done`.
- `v_disp`  out  11  measured active line count, updated at `frame_done`.
- `fmt_err`  out  1  frame error (unequal line widths or overflow), updated at `frame_done`.
- `locked`  out  1  stable format detected.
- `res_id`  out  16  decoded panel ID.

## Operation
- States:
  - **IDLE**: entered after reset. Counts consecutive DE-low cycles. When the count reaches `VBLANK_MIN`, go to SYNC. A DE-high cycle clears the count. Pixels arriving in IDLE are discarded, so `pixel_valid` stays 0.
  - **SYNC**: waiting for the first DE of a frame. DE=1 goes to ACTIVE, sets x=0, y=0 and pulses `frame_start`.
  - **ACTIVE**: while DE=1, x increments and saturates at 2047; reaching 2047 sets the internal error flag. DE=0 goes to HBLANK, pulses `line_done`, and records the line width (x+1):
    - first line of the frame: store it as the reference width;
    - later lines: a width different from the reference sets the error flag.
  - **HBLANK**: counts DE-low cycles, saturating at `VBLANK_MIN`.
    - DE=1 before the count reaches `VBLANK_MIN`: go to ACTIVE with x=0, y=y+1; y saturates at 2047 and sets the error flag.
    - Count reaches `VBLANK_MIN`: pulse `frame_done`; load `h_disp` with the reference width, `v_disp` with y+1, and `fmt_err` with the error flag; clear the error flag; go to SYNC.
- Lock:
  - `locked` is set at a `frame_done` with `fmt_err`=0 and `h_disp`/`v_disp` equal to the previous frame's values.
  - `locked` is cleared at any `frame_done` that does not meet that condition.
  - The first frame after reset can never lock.
- Outputs: `pixel_xpos`/`pixel_ypos` are 0 whenever `pixel_valid`=0. `pixel_data` is 24'd0 whenever `pixel_valid`=0.
- Reset: asynchronous assertion at any time (including mid-line or mid-frame) forces IDLE, clears all counters, and drives every output to 0, including `res_id`. The partial frame after reset release is discarded by the IDLE qualification.

## Timing
- Latency is one register stage: input DE/RGB sampled at edge N appear on `pixel_valid`/`pixel_data`/`pixel_xpos`/`pixel_ypos` after edge N+1.
- `frame_start` is coincident with the first `pixel_valid` of a frame.
- `line_done` is asserted the cycle after the last `pixel_valid` of a line (the first registered DE-low cycle).
- `frame_done` is asserted in the cycle in which the registered blank count equals `VBLANK_MIN`. `h_disp`, `v_disp`, `fmt_err` and `locked` change on that same edge.
- A one-cycle DE-low gap inside a frame is a legal line boundary.
- DE high continuously never produces `line_done`. x saturates at 2047 and the error flag is set.
- There is no backpressure; the downstream side must accept one pixel per clock.

## Configuration
- `LCD_RX_ID_DECODE_EN` defined:
  - `res_id` is registered at each `frame_done` from the new `h_disp`/`v_disp` values:
    - 480×272 → 16'h4342
    - 800×480 → 16'h7084
    - 1024×600 → 16'h7016
    - 1280×800 → 16'h1018
    - anything else → 16'h0000
  - `res_id` is forced to 16'h0000 whenever `fmt_err`=1.
- `LCD_RX_ID_DECODE_EN` not defined: `res_id` is tied to 16'h0000 and no compare logic is synthesised.

## Test plan
- Three frames of 480×272 (H total 525, V total 286, `VBLANK_MIN`=4096) → `frame_done` ×2 (frames 2 and 3; frame 1 is discarded in IDLE), `h_disp`=480, `v_disp`=272, `fmt_err`=0, `locked`=1 at the second `frame_done`, `res_id`=16'h4342 with macro, 16'h0000 without.
- 1024×600 stream (H 1344, V 635) → per line, `pixel_xpos` steps 0..1023 then `line_done`; `frame_start` coincides with (0,0); `res_id`=16'h7016; latency exactly 1 cycle from `lcd_de` to `pixel_valid`.
- Locked 800×480 stream, with one line of frame k shortened to 799 pixels → at frame k's `frame_done`: `fmt_err`=1, `locked`=0, `res_id`=0. After two clean frames: `locked`=1, `res_id`=16'h7084.
- Assert `rst_n` low at pixel (300,100), release 10 cycles later → all outputs 0 during reset; no `pixel_valid` until a 4096-cycle blank has been seen; the next full frame measures correctly.
- Hold DE high for 3000 cycles, then blank for 5000 cycles → `pixel_xpos` saturates at 2047; `frame_done` with `fmt_err`=1, `locked`=0.
- Frame containing DE gaps of 1 cycle between lines → every gap is counted as a line boundary and `v_disp` equals the line count.

Source files
------------

// File: rtl/lcd_rx_timing.sv
// lcd_rx_timing
//   Receive-side timing recovery for a DE-mode RGB888 video stream. It frames the
//   stream from DE alone, tags every accepted pixel with its column/row, measures
//   the active resolution of each frame, compares it with the previous frame, and
//   reports a lock flag plus a decoded panel ID.
//
//   Optional feature macro: LCD_RX_ID_DECODE_EN
//     defined     -> res_id is decoded from h_disp/v_disp at each frame_done
//     not defined -> res_id is tied to 16'h0000
//
// Ports
//   lcd_pclk     in   pixel clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   lcd_de       in   data enable
//   lcd_rgb      in   [23:0] pixel data, meaningful while lcd_de=1
//   pixel_valid  out  registered lcd_de, only while a frame is being tracked
//   pixel_data   out  [23:0] registered lcd_rgb, 0 when pixel_valid=0
//   pixel_xpos   out  [10:0] column of the current pixel, 0 when pixel_valid=0
//   pixel_ypos   out  [10:0] row of the current pixel, 0 when pixel_valid=0
//   frame_start  out  pulse with pixel (0,0)
//   line_done    out  pulse in the first registered DE-low cycle after a line
//   frame_done   out  pulse when the blank run reaches VBLANK_MIN
//   h_disp       out  [10:0] measured active width
//   v_disp       out  [10:0] measured active line count
//   fmt_err      out  unequal line widths or counter overflow in the last frame
//   locked       out  format stable over two consecutive frames
//   res_id       out  [15:0] decoded panel ID
//
// Handshake: there is no backpressure. pixel_valid is a one-cycle qualifier for
// pixel_data/pixel_xpos/pixel_ypos and the consumer must take every such cycle.
module lcd_rx_timing #(
    parameter int VBLANK_MIN = 4096
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        lcd_de,
    input  logic [23:0] lcd_rgb,
    output logic        pixel_valid,
    output logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic        line_done,
    output logic        frame_done,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        fmt_err,
    output logic        locked,
    output logic [15:0] res_id
);

    localparam int              CW   = $clog2(VBLANK_MIN + 1);
    localparam logic [CW-1:0]   VB   = CW'(VBLANK_MIN);
    localparam logic [10:0]     CMAX = 11'd2047;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_HBLANK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [10:0]   x_q, x_d, y_q, y_d, ref_q, ref_d;
    logic [10:0]   h_q, h_d, v_q, v_d;
    logic [10:0]   line_w, frame_h;
    logic [23:0]   data_q, data_d;
    logic          err_q, err_d, first_q, first_d, prev_q, prev_d;
    logic          valid_q, valid_d, fs_q, fs_d, ld_q, ld_d, fd_q, fd_d;
    logic          fe_q, fe_d, lock_q, lock_d;

    assign cnt_inc = cnt_q + CW'(1);
    // Width/height of 2048 cannot be represented in 11 bits; hold them at 2047.
    // Either case has already raised the error flag.
    assign line_w  = (x_q == CMAX) ? CMAX : x_q + 11'd1;
    assign frame_h = (y_q == CMAX) ? CMAX : y_q + 11'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        first_d = first_q;
        ref_d   = ref_q;
        prev_d  = prev_q;
        valid_d = 1'b0;
        data_d  = '0;
        fs_d    = 1'b0;
        ld_d    = 1'b0;
        fd_d    = 1'b0;
        h_d     = h_q;
        v_d     = v_q;
        fe_d    = fe_q;
        lock_d  = lock_q;
        unique case (state_q)
            S_IDLE: begin
                // Wait for a full vertical blank before trusting the framing.
                if (lcd_de) begin
                    cnt_d = '0;
                end else if (cnt_inc == VB) begin
                    cnt_d   = VB;
                    state_d = S_SYNC;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SYNC: begin
                cnt_d = '0;
                if (lcd_de) begin
                    state_d = S_ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    first_d = 1'b1;
                    valid_d = 1'b1;
                    data_d  = lcd_rgb;
                    fs_d    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (lcd_de) begin
                    valid_d = 1'b1;
                    data_d  = lcd_rgb;
                    if (x_q != CMAX) x_d = x_q + 11'd1;
                    if (x_q >= CMAX - 11'd1) err_d = 1'b1;
                end else begin
                    state_d = S_HBLANK;
                    ld_d    = 1'b1;
                    // This DE-low cycle is the first of the blank run.
                    cnt_d   = CW'(1);
                    if (first_q) begin
                        ref_d   = line_w;
                        first_d = 1'b0;
                    end else if (line_w != ref_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                if (lcd_de) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    x_d     = '0;
                    valid_d = 1'b1;
                    data_d  = lcd_rgb;
                    if (y_q != CMAX) y_d = y_q + 11'd1;
                    if (y_q >= CMAX - 11'd1) err_d = 1'b1;
                end else if (cnt_inc == VB) begin
                    state_d = S_SYNC;
                    cnt_d   = VB;
                    fd_d    = 1'b1;
                    h_d     = ref_q;
                    v_d     = frame_h;
                    fe_d    = err_q;
                    // h_q/v_q still hold the previous frame's measurement here;
                    // prev_q keeps the first frame after reset from locking.
                    lock_d  = !err_q && prev_q && (ref_q == h_q) && (frame_h == v_q);
                    prev_d  = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            ref_q   <= '0;
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            fs_q    <= 1'b0;
            ld_q    <= 1'b0;
            fd_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            fe_q    <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
            first_q <= first_d;
            ref_q   <= ref_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            fs_q    <= fs_d;
            ld_q    <= ld_d;
            fd_q    <= fd_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fe_q    <= fe_d;
            lock_q  <= lock_d;
        end
    end

`ifdef LCD_RX_ID_DECODE_EN
    function automatic logic [15:0] decode_id(input logic [10:0] h, input logic [10:0] v);
        logic [15:0] id;
        id = 16'h0000;
        if      (h == 11'd480  && v == 11'd272) id = 16'h4342;
        else if (h == 11'd800  && v == 11'd480) id = 16'h7084;
        else if (h == 11'd1024 && v == 11'd600) id = 16'h7016;
        else if (h == 11'd1280 && v == 11'd800) id = 16'h1018;
        return id;
    endfunction

    logic [15:0] res_id_q, res_id_d;

    always_comb begin
        res_id_d = res_id_q;
        // fmt_err only changes at frame_done, so gating here keeps res_id at 0
        // for exactly as long as fmt_err is 1.
        if (fd_d) res_id_d = err_q ? 16'h0000 : decode_id(ref_q, frame_h);
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) res_id_q <= '0;
        else        res_id_q <= res_id_d;
    end

    assign res_id = res_id_q;
`else
    assign res_id = 16'h0000;
`endif

    // Coordinates are forced to 0 outside valid pixels; the counters keep
    // their values across the horizontal blank.
    assign pixel_valid = valid_q;
    assign pixel_data  = data_q;
    assign pixel_xpos  = valid_q ? x_q : 11'd0;
    assign pixel_ypos  = valid_q ? y_q : 11'd0;
    assign frame_start = fs_q;
    assign line_done   = ld_q;
    assign frame_done  = fd_q;
    assign h_disp      = h_q;
    assign v_disp      = v_q;
    assign fmt_err     = fe_q;
    assign locked      = lock_q;

endmodule
